// File: rtl/dmem_lsu.sv
// Byte-lane data memory for the MEM stage: valid/ready requests, sized and extended loads,
// RD_LAT-deep response pipe, clear-on-reset sweep. Optional lane parity via DMEM_PARITY_EN.
module dmem_lsu #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [63:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_PARITY_EN
  input  logic              dbg_flip_par,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault
);

  localparam int NB     = DATA_W / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int ADDR_W = OFF_W + IDX_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] init_cnt_reg;
  logic             init_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_INIT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_INIT && init_cnt_reg == IDX_W'(DEPTH - 1))
      state_next = ST_RUN;
  end

  always_comb begin
    req_ready = (state_reg == ST_RUN);
    init_we   = (state_reg == ST_INIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       init_cnt_reg <= '0;
    else if (init_we) init_cnt_reg <= init_cnt_reg + 1'b1;
  end

  // Request decode
  logic             accept;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic [2:0]       off3, size_mask3;
  logic             req_fault;
  logic [NB-1:0]    lane_base, lane_mask;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^req_addr[63:ADDR_W];

  always_comb begin
    accept  = req_valid && req_ready;
    req_idx = req_addr[ADDR_W-1:OFF_W];
    req_off = req_addr[OFF_W-1:0];
    off3    = 3'(req_off);
    case (req_size)
      2'd0:    begin size_mask3 = 3'b000; lane_base = NB'(8'h01); end
      2'd1:    begin size_mask3 = 3'b001; lane_base = NB'(8'h03); end
      2'd2:    begin size_mask3 = 3'b011; lane_base = NB'(8'h0F); end
      default: begin size_mask3 = 3'b111; lane_base = NB'(8'hFF); end
    endcase
    req_fault = (|(off3 & size_mask3)) || (DATA_W == 32 && req_size == 2'd3);
    lane_mask = lane_base << req_off;
  end

  // Shared write port: the init sweep owns it until RUN
  logic [IDX_W-1:0]  wr_idx;
  logic [NB-1:0]     wr_be;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    if (init_we) begin
      wr_idx  = init_cnt_reg;
      wr_be   = '1;
      wr_data = '0;
    end else begin
      wr_idx  = req_idx;
      wr_be   = (accept && req_we && !req_fault) ? lane_mask : '0;
      wr_data = req_wdata << {req_off, 3'b000};
    end
  end

  // Stage 0: registered read plus request metadata
  logic              s0_valid_reg, s0_we_reg, s0_signed_reg, s0_fault_reg;
  logic [1:0]        s0_size_reg;
  logic [OFF_W-1:0]  s0_off_reg;
  logic [DATA_W-1:0] rd_word;
`ifdef DMEM_PARITY_EN
  logic [NB-1:0]     s0_lanes_reg;
  logic [NB-1:0]     par_err_lane;
  logic              wr_flip;
  assign wr_flip = dbg_flip_par && !init_we;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_reg  <= 1'b0;
      s0_we_reg     <= 1'b0;
      s0_signed_reg <= 1'b0;
      s0_fault_reg  <= 1'b0;
      s0_size_reg   <= '0;
      s0_off_reg    <= '0;
`ifdef DMEM_PARITY_EN
      s0_lanes_reg  <= '0;
`endif
    end else begin
      s0_valid_reg <= accept;
      if (accept) begin
        s0_we_reg     <= req_we;
        s0_signed_reg <= req_signed;
        s0_fault_reg  <= req_fault;
        s0_size_reg   <= req_size;
        s0_off_reg    <= req_off;
`ifdef DMEM_PARITY_EN
        s0_lanes_reg  <= lane_mask;
`endif
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_byte_reg;
    always_ff @(posedge clk) begin
      if (wr_be[gi]) lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
      if (accept)    rd_byte_reg <= lane_mem[req_idx];
    end
    assign rd_word[gi*8 +: 8] = rd_byte_reg;
`ifdef DMEM_PARITY_EN
    logic lane_par [DEPTH];
    logic rd_par_reg;
    always_ff @(posedge clk) begin
      if (wr_be[gi]) lane_par[wr_idx] <= (^wr_data[gi*8 +: 8]) ^ wr_flip;
      if (accept)    rd_par_reg <= lane_par[req_idx];
    end
    assign par_err_lane[gi] = s0_lanes_reg[gi] & (rd_par_reg ^ (^rd_byte_reg));
`endif
  end

  // Align selected bytes to bit 0 and extend
  logic [DATA_W-1:0] shifted, lo_mask, ext_rdata;
  logic              sbit, ext_fault;

  always_comb begin
    shifted = rd_word >> {s0_off_reg, 3'b000};
    case (s0_size_reg)
      2'd0:    begin lo_mask = DATA_W'(8'hFF);         sbit = shifted[7];        end
      2'd1:    begin lo_mask = DATA_W'(16'hFFFF);      sbit = shifted[15];       end
      2'd2:    begin lo_mask = DATA_W'(32'hFFFF_FFFF); sbit = shifted[31];       end
      default: begin lo_mask = '1;                     sbit = shifted[DATA_W-1]; end
    endcase
    if (s0_we_reg || s0_fault_reg)
      ext_rdata = '0;
    else
      ext_rdata = (shifted & lo_mask) | ((s0_signed_reg && sbit) ? ~lo_mask : '0);
`ifdef DMEM_PARITY_EN
    ext_fault = s0_fault_reg | (!s0_we_reg && (|par_err_lane));
`else
    ext_fault = s0_fault_reg;
`endif
  end

  // Response pipe; data only moves with a valid so outputs hold between responses
  for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
    logic              in_valid, in_fault;
    logic [DATA_W-1:0] in_data;
    logic              valid_reg, fault_reg;
    logic [DATA_W-1:0] data_reg;
    if (gi == 0) begin : g_first
      assign in_valid = s0_valid_reg;
      assign in_data  = ext_rdata;
      assign in_fault = ext_fault;
    end else begin : g_chain
      assign in_valid = g_stage[gi-1].valid_reg;
      assign in_data  = g_stage[gi-1].data_reg;
      assign in_fault = g_stage[gi-1].fault_reg;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
        fault_reg <= 1'b0;
      end else begin
        valid_reg <= in_valid;
        if (in_valid) begin
          data_reg  <= in_data;
          fault_reg <= in_fault;
        end
      end
    end
  end

  assign rsp_valid = g_stage[RD_LAT-1].valid_reg;
  assign rsp_rdata = g_stage[RD_LAT-1].data_reg;
  assign rsp_fault = g_stage[RD_LAT-1].fault_reg;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu (DATA_W=64, DEPTH=1024, RD_LAT=3): directed vector table, hand-written
// latency/reset sequences, and random traffic against a byte-addressed reference memory.
module tb_dmem_lsu;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 3;
  localparam int NB     = DATA_W / 8;
  localparam int MEMB   = DEPTH * NB;

  logic              clk, rst_n, req_valid, req_ready, req_we, req_signed;
  logic [1:0]        req_size;
  logic [63:0]       req_addr;
  logic [DATA_W-1:0] req_wdata, rsp_rdata;
  logic              rsp_valid, rsp_fault;
`ifdef DMEM_PARITY_EN
  logic              dbg_flip_par;
`endif

  dmem_lsu #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_PARITY_EN
    .dbg_flip_par(dbg_flip_par),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int          due;
  } exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[16];
  logic [7:0]  ref_mem [MEMB];
  int          errors, checks, cyc;
  logic [63:0] last_rdata;
  logic        last_fault;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
      chk("rsp_fault", rsp_fault, exp_q[0].fault);
      $display("rsp cycle %0d: rdata=0x%016h fault=%0d", cyc, rsp_rdata, rsp_fault);
      last_rdata = exp_q[0].rdata;
      last_fault = exp_q[0].fault;
      void'(exp_q.pop_front());
    end else begin
      chk("idle rsp_valid", rsp_valid, 0);
      chk("hold rsp_rdata", rsp_rdata, last_rdata);
      chk("hold rsp_fault", rsp_fault, last_fault);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;
  endtask

  // Byte-addressed reference: little-endian bytes, aliasing by modulo of the memory size
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       output logic [63:0] rdata, output logic fault);
    int a, sb;
    a     = int'(addr % 64'(MEMB));
    sb    = 1 << size;
    fault = (a % sb) != 0;
    rdata = 64'd0;
    if (!fault) begin
      if (we) begin
        for (int j = 0; j < sb; j++) ref_mem[a + j] = wdata[8*j +: 8];
      end else begin
        for (int j = 0; j < sb; j++) rdata = rdata | (64'(ref_mem[a + j]) << (8 * j));
        if (sgn && sb < 8 && rdata[8*sb - 1])
          rdata = rdata | ~((64'd1 << (8 * sb)) - 64'd1);
      end
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input bit use_exp, input logic [63:0] exp_rdata, input logic exp_fault);
    logic [63:0] m_rd;
    logic        m_f;
    exp_t        e;
    chk("req_ready at issue", req_ready, 1);
    model(we, size, sgn, addr, wdata, m_rd, m_f);
    e.rdata = use_exp ? exp_rdata : m_rd;
    e.fault = use_exp ? exp_fault : m_f;
    e.due   = cyc + 1 + RD_LAT;
    exp_q.push_back(e);
    $display("req cycle %0d: we=%0d size=%0d sgn=%0d addr=0x%h wdata=0x%h", cyc, we, size, sgn, addr, wdata);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain pending responses", 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!req_ready && n < DEPTH + 20) begin
      step();
      n++;
    end
    chk(name, 64'(n), 64'(DEPTH));
  endtask

  initial begin
    logic [1:0]  sz;
    logic [63:0] a;
    errors = 0; checks = 0; cyc = 0;
    last_rdata = '0; last_fault = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
`ifdef DMEM_PARITY_EN
    dbg_flip_par = 1'b0;
`endif
    clear_model();

    vecs[0]  = '{"init dword 0x18",     0, 2'd3, 0, 64'h18,   64'h0, 64'h0, 0};
    vecs[1]  = '{"store byte 0x5",      1, 2'd0, 0, 64'h5,    64'h80, 64'h0, 0};
    vecs[2]  = '{"load byte s 0x5",     0, 2'd0, 1, 64'h5,    64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0};
    vecs[3]  = '{"load byte u 0x5",     0, 2'd0, 0, 64'h5,    64'h0, 64'h80, 0};
    vecs[4]  = '{"store dword 0x40",    1, 2'd3, 0, 64'h40,   64'h1122334455667788, 64'h0, 0};
    vecs[5]  = '{"store half 0x42",     1, 2'd1, 0, 64'h42,   64'hBEEF, 64'h0, 0};
    vecs[6]  = '{"lane merge 0x40",     0, 2'd3, 0, 64'h40,   64'h0, 64'h11223344BEEF7788, 0};
    vecs[7]  = '{"misaligned store",    1, 2'd1, 0, 64'h43,   64'hAAAA, 64'h0, 1};
    vecs[8]  = '{"unchanged 0x40",      0, 2'd3, 0, 64'h40,   64'h0, 64'h11223344BEEF7788, 0};
    vecs[9]  = '{"misaligned word ld",  0, 2'd2, 0, 64'h42,   64'h0, 64'h0, 1};
    vecs[10] = '{"alias store 0x2008",  1, 2'd3, 0, 64'h2008, 64'hCAFEF00D12345678, 64'h0, 0};
    vecs[11] = '{"alias load 0x8",      0, 2'd3, 0, 64'h8,    64'h0, 64'hCAFEF00D12345678, 0};
    vecs[12] = '{"word s 0x40",         0, 2'd2, 1, 64'h40,   64'h0, 64'hFFFF_FFFF_BEEF_7788, 0};
    vecs[13] = '{"word u 0x44",         0, 2'd2, 0, 64'h44,   64'h0, 64'h11223344, 0};
    vecs[14] = '{"half s 0x46",         0, 2'd1, 1, 64'h46,   64'h0, 64'h1122, 0};
    vecs[15] = '{"byte s 0x41",         0, 2'd0, 1, 64'h41,   64'h0, 64'h77, 0};

    repeat (3) step();
    chk("reset req_ready", req_ready, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset rsp_fault", rsp_fault, 0);
    rst_n = 1'b1;
    wait_init("init length");

    for (int i = 0; i < 16; i++) begin
      $display("vector %0d: %s", i, vecs[i].name);
      issue(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
            1, vecs[i].exp_rdata, vecs[i].exp_fault);
      drain();
    end

    // Store then load of the same entry on consecutive cycles
    issue(1, 2'd2, 0, 64'h100, 64'hDEAD_BEEF, 1, 64'h0, 0);
    issue(0, 2'd2, 0, 64'h100, 64'h0, 1, 64'hDEAD_BEEF, 0);
    drain();

    // Four back-to-back loads: responses due on consecutive cycles, RD_LAT after accept
    issue(0, 2'd3, 0, 64'h40,  64'h0, 0, 64'h0, 0);
    issue(0, 2'd3, 0, 64'h8,   64'h0, 0, 64'h0, 0);
    issue(0, 2'd2, 1, 64'h100, 64'h0, 0, 64'h0, 0);
    issue(0, 2'd0, 0, 64'h5,   64'h0, 0, 64'h0, 0);
    drain();

    // Reset in the middle of a stream drops everything in flight
    issue(0, 2'd3, 0, 64'h40, 64'h0, 0, 64'h0, 0);
    issue(0, 2'd3, 0, 64'h8,  64'h0, 0, 64'h0, 0);
    issue(0, 2'd3, 0, 64'h0,  64'h0, 0, 64'h0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid-stream reset req_ready", req_ready, 0);
    chk("mid-stream reset rsp_valid", rsp_valid, 0);
    exp_q.delete();
    last_rdata = '0;
    last_fault = 1'b0;
    clear_model();
    repeat (4) step();
    rst_n = 1'b1;
    wait_init("re-init length");
    issue(0, 2'd3, 0, 64'h40, 64'h0, 1, 64'h0, 0);
    drain();

    // Random traffic around a small window, with random upper bits to exercise aliasing
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
      end else begin
        sz = 2'($urandom_range(0, 3));
        a  = ({$urandom, $urandom} & ~64'h1FFF) | 64'($urandom_range(0, 255));
        if ($urandom_range(0, 9) < 8) a = a & ~((64'd1 << sz) - 64'd1);
        issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
              {$urandom, $urandom}, 0, 64'h0, 0);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
